// File: rtl/rgb_sbitn2wrd.sv
// Serial bit strobes to DATA_BITS-wide pixel words, tagged with status and
// pixel index, buffered in a first-word-fall-through FIFO with valid/ready.
module rgb_sbitn2wrd #(
    parameter int DATA_BITS    = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int PIX_W        = 10,
    parameter bit MERGE_RESETS = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          strobe,
    input  logic                          sbit_value,
    input  logic                          stream_reset,
    output logic [DATA_BITS+7:0]          out_word,
    output logic [PIX_W-1:0]              out_pix,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf_sticky
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam int WW = DATA_BITS + 8;
    localparam logic [BW-1:0] TOP = BW'(DATA_BITS - 1);

    logic [1:0]           sync;
    logic                 run;
    logic                 strobe_d;
    logic                 rst_seen;
    logic                 ovf_pending;
    logic [BW-1:0]        bcount;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] filled;
    logic [PIX_W-1:0]     pix_cnt;

    logic                 ev;
    logic                 merge_skip;
    logic                 push_req;
    logic [WW-1:0]        push_word;
    logic                 pop;
    logic                 full;
    logic                 accept;
    logic                 drop;

    logic [WW-1:0]        mem_word [FIFO_DEPTH];
    logic [PIX_W-1:0]     mem_pix  [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    // Reset release is synchronised; logic only acts once sync[1] is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b00;
        else      sync <= {sync[0], 1'b1};
    end
    assign run = sync[1];

    assign ev         = run && strobe && !strobe_d;
    assign merge_skip = MERGE_RESETS && rst_seen;

    always_comb begin
        filled         = shreg;
        filled[bcount] = sbit_value;
        push_req       = 1'b0;
        push_word      = '0;
        if (ev) begin
            if (!stream_reset) begin
                if (bcount == '0) begin
                    push_req  = 1'b1;
                    push_word = {1'b1, 1'b0, 1'b0, ovf_pending, 4'b0000, filled};
                end
            end else if (!merge_skip) begin
                // shreg holds received bits left-aligned, zeros below.
                push_req  = 1'b1;
                push_word = {1'b1, 1'b1, (bcount != TOP), ovf_pending, 4'b0000, shreg};
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign accept    = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_d    <= 1'b0;
            rst_seen    <= 1'b0;
            bcount      <= TOP;
            shreg       <= '0;
            pix_cnt     <= '0;
            ovf_pending <= 1'b0;
            ovf_sticky  <= 1'b0;
        end else begin
            strobe_d <= strobe;
            if (ev) begin
                if (!stream_reset) begin
                    rst_seen <= 1'b0;
                    if (bcount == '0) begin
                        shreg  <= '0;
                        bcount <= TOP;
                        if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
                    end else begin
                        shreg  <= filled;
                        bcount <= bcount - 1'b1;
                    end
                end else if (!merge_skip) begin
                    shreg    <= '0;
                    bcount   <= TOP;
                    pix_cnt  <= '0;
                    rst_seen <= 1'b1;
                end
            end
            if (accept)    ovf_pending <= 1'b0;
            else if (drop) ovf_pending <= 1'b1;
            if (drop) ovf_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !accept) fifo_count <= fifo_count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_word[wr_ptr] <= push_word;
            mem_pix[wr_ptr]  <= pix_cnt;
        end
    end

    assign out_word = out_valid ? mem_word[rd_ptr] : '0;
    assign out_pix  = out_valid ? mem_pix[rd_ptr]  : '0;

endmodule
